// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract: the carry chain is cut into STAGES chunks of
// N/STAGES bits with the carry registered between chunks, a valid/ready
// handshake with backpressure, carry-in, subtract mode and signed overflow.
module pipelined_adder #(
  parameter int unsigned N      = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_add1,
  input  logic [N-1:0] i_add2,
  input  logic         i_carry,
  input  logic         i_sub,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_overflow
);

  localparam int unsigned STAGES_SAFE = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned W           = (N / STAGES_SAFE == 0) ? 1 : N / STAGES_SAFE;

  // Reject configurations that cannot be split into equal chunks
  if ((N < 1) || (STAGES < 1) || (STAGES > N) || ((N % STAGES_SAFE) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: need N >= 1, 1 <= STAGES <= N and N %% STAGES == 0");
  end

  // Whole pipeline advances together; a held output blocks every stage
  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Per-stage inputs: index 0 is the conditioned operand beat, index k>0 is
  // the register set written by stage k-1
  logic [N-1:0]      a_src [STAGES];
  logic [N-1:0]      b_src [STAGES];
  logic [N-1:0]      r_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;

  // Subtraction is A + ~B + 1; carry-in is only honoured for addition
  assign a_src[0] = i_add1;
  assign b_src[0] = i_sub ? ~i_add2 : i_add2;
  assign r_src[0] = '0;
  assign c_src[0] = i_sub ? 1'b1 : i_carry;
  assign v_src[0] = i_valid;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [W:0]   sum_ext;
    logic [N-1:0] r_next;
    logic [N-1:0] r_q;
    logic         c_q;
    logic         v_q;

    assign sum_ext = (W+1)'(a_src[s][s*W +: W])
                   + (W+1)'(b_src[s][s*W +: W])
                   + (W+1)'(c_src[s]);

    // Merge this stage's chunk into the partial result from earlier stages
    always_comb begin
      r_next = r_src[s];
      r_next[s*W +: W] = sum_ext[W-1:0];
    end

    // Result, carry and valid register for this chunk
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_src[s];
        c_q <= sum_ext[W];
        r_q <= r_next;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;

      // Carry the operands forward for the chunks not yet added
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_src[s];
          b_q <= b_src[s];
        end
      end

      assign a_src[s+1] = a_q;
      assign b_src[s+1] = b_q;
      assign r_src[s+1] = r_q;
      assign c_src[s+1] = c_q;
      assign v_src[s+1] = v_q;
    end else begin : g_last
      logic msb_cin;
      logic ov_q;

      // Carry into the MSB recovered from the MSB's own sum bit
      assign msb_cin = a_src[s][N-1] ^ b_src[s][N-1] ^ sum_ext[W-1];

      // Signed overflow registered alongside the final chunk
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          ov_q <= 1'b0;
        end else if (en) begin
          ov_q <= msb_cin ^ sum_ext[W];
        end
      end

      assign o_valid    = v_q;
      assign o_result   = r_q;
      assign o_carry    = c_q;
      assign o_overflow = ov_q;
    end
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's N-bit carry-chain adder.
- Splits the N-bit add/subtract into STAGES chunks of N/STAGES bits. The carry is registered between chunks, so timing is set by one chunk rather than the full ripple chain.
- Adds carry-in, subtract mode, signed overflow and a valid/ready handshake with backpressure.
- Sits between operand registers and accumulator/ALU-result logic in the datapath.

Parameters:
- N, 16, operand and result width. Must be ≥ 1.
- STAGES, 4, number of pipeline stages and carry-chain chunks. Must satisfy 1 ≤ STAGES ≤ N and N % STAGES == 0. Elaboration error otherwise.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  operand beat valid.
- o_ready  output  1  pipeline can accept a beat this cycle.
- i_add1  input  N  operand A.
- i_add2  input  N  operand B.
- i_carry  input  1  carry-in, used only when i_sub = 0.
- i_sub  input  1  1 selects A − B, 0 selects A + B + i_carry.
- o_valid  output  1  result beat valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  N  sum or difference.
- o_carry  output  1  carry-out of bit N−1. In subtract mode, 1 means no borrow.
- o_overflow  output  1  two's-complement signed overflow.

Behaviour:
- Chunk width W = N/STAGES. Stage k (0..STAGES−1) adds bits [k·W+W−1 : k·W].
- Operand conditioning at stage 0 input:
  - B' = i_sub ? ~i_add2 : i_add2.
  - cin = i_sub ? 1 : i_carry.
- Per stage k:
  - Computes its chunk from the delayed A/B' chunk plus the carry registered by stage k−1 (stage 0 uses cin).
  - Registers its result chunk, carry-out, valid bit, and the not-yet-consumed upper operand chunks.
  - Passes lower result chunks forward unchanged.
- Final stage: o_overflow = carry into bit N−1 XOR carry out of bit N−1, registered with the result.
- Pipeline advance:
  - en = ~o_valid | i_ready.
  - o_ready = en (combinational, no dependency on i_valid).
  - When en = 1, every stage loads from its predecessor and stage 0 loads from the inputs. Its valid bit takes i_valid.
  - When en = 0, all stages hold.
  - Bubbles are not compressed internally.
- Handshakes:
  - Input beat accepted when i_valid & o_ready.
  - Output beat consumed when o_valid & i_ready.
- Latency: exactly STAGES cycles from acceptance to o_valid when never stalled. Throughput is 1 beat/cycle.
- Stall: while o_valid = 1 and i_ready = 0, o_result, o_carry, o_overflow and o_valid are held stable, and no input is accepted.
- Data outputs while o_valid = 0 are don't-care for checking, but must be deterministic (no X after reset).
- Reset:
  - i_rst = 1 at a clock edge clears all stage valid bits, data registers and carries to 0. Therefore o_valid = 0, o_result = 0, o_carry = 0, o_overflow = 0, o_ready = 1.
  - Reset mid-operation discards all in-flight beats. None emerge afterwards.
  - Inputs presented during a reset cycle are ignored.
- Wrap-around: result is modulo 2^N. Carry-out reports the wrap.
- STAGES = 1 degenerates to a single registered adder with latency 1.
- STAGES = N gives 1-bit chunks, one register per bit.

Test Plan (N=16, STAGES=4 unless noted):
- Unsigned wrap: 0xFFFF + 0x0001, i_carry = 0, i_ready = 1. Result 0x0000, carry 1, overflow 0, exactly 4 cycles after acceptance.
- Signed overflow: 0x7FFF + 0x0001. Result 0x8000, carry 0, overflow 1. Also 0x1234 + 0x1111 with i_carry = 1 gives 0x2346, carry 0, overflow 0.
- Subtract: 0x0005 − 0x0007 gives 0xFFFE, carry 0 (borrow), overflow 0. 0x8000 − 0x0001 gives 0x7FFF, carry 1, overflow 1.
- Throughput/backpressure:
  - Stream 8 back-to-back beats (A = k, B = 0x0100·k) with i_ready = 1. Results arrive on 8 consecutive cycles in order.
  - Drop i_ready for 3 cycles mid-stream. Outputs hold, o_ready = 0, no beat lost or duplicated.
- Reset mid-operation: accept 2 beats, assert i_rst for 1 cycle at cycle 2. o_valid stays 0 for all following cycles until new input. o_ready = 1 the cycle after reset.
- Config sweep: repeat the 0xFFFF + 0x0001 and subtract cases with STAGES = 1 and N = 8, STAGES = 8. Latency 1 and 8 respectively. Compare against a reference model over 1000 random operands, random i_sub, i_carry and i_ready.
